// File: rtl/operand_read_pkg.sv
// Shared types for the operand read stage.
//   NR / OP_W / IDX_W  : register count, operation field width, register index width
//   regval_t, regfile_t: one 32-bit register value and the full register file snapshot
//   state_t            : operand read FSM states
//   operand_bundle_t   : one resolved operation, used for both the holding and output registers
//   read_reg()         : register read where index 0 always reads as zero
package operand_read_pkg;

  localparam int NR    = 16;
  localparam int OP_W  = 8;
  localparam int IDX_W = $clog2(NR);

  typedef logic [31:0]         regval_t;
  typedef regval_t [NR-1:0]    regfile_t;
  typedef logic [IDX_W-1:0]    regidx_t;

  typedef enum logic [1:0] {
    PASS      = 2'd0,
    MEM_WAIT  = 2'd1,
    DATA_HELD = 2'd2
  } state_t;

  typedef struct packed {
    regval_t         pc;
    logic [OP_W-1:0] operation;
    regval_t         left_value;
    regval_t         right_value;
    regidx_t         destination;
    regval_t         destination_address;
    logic            destination_is_memory;
    logic            has_flushed;
  } operand_bundle_t;

  function automatic regval_t read_reg(regfile_t regs, regidx_t idx);
    return (idx == '0) ? '0 : regs[idx];
  endfunction

endpackage

// File: rtl/operand_read_if.sv
// Data-memory read bus between the operand read stage and data memory.
//   address_enable : read request, held high until data returns
//   address        : read address, stable while address_enable is high
//   data_valid     : memory has returned read data this cycle
//   data           : read data
// master = operand read stage, slave = memory.
interface operand_read_if;

  logic        address_enable;
  logic [31:0] address;
  logic        data_valid;
  logic [31:0] data;

  modport master (
    output address_enable,
    output address,
    input  data_valid,
    input  data
  );

  modport slave (
    input  address_enable,
    input  address,
    output data_valid,
    output data
  );

endinterface

// File: rtl/operand_read_adjust.sv
// Combinational operand resolution.
//   registers            : register file snapshot
//   left/right_register  : source indices (index 0 reads as zero)
//   adjustment           : signed immediate/offset
//   adjustment_operation : 0 = add, 1 = subtract
//   left_value           : reg(left)
//   adjusted_value       : reg(right) +/- adjustment, 32-bit wrap-around
module operand_read_adjust
  import operand_read_pkg::*;
(
  input  regfile_t registers,
  input  regidx_t  left_register,
  input  regidx_t  right_register,
  input  regval_t  adjustment,
  input  logic     adjustment_operation,
  output regval_t  left_value,
  output regval_t  adjusted_value
);

  regval_t right_raw;

  assign left_value = read_reg(registers, left_register);
  assign right_raw  = read_reg(registers, right_register);

  assign adjusted_value = adjustment_operation ? (right_raw - adjustment)
                                               : (right_raw + adjustment);

endmodule

// File: rtl/operand_read.sv
// Operand read pipeline stage between decode and execute.
//   clock, reset_n       : system clock, async active-low reset
//   hold_n               : execute ready; 0 freezes the output registers
//   input_valid, in_*    : decode-to-read bundle; registers = register file snapshot
//   wait_n               : back-pressure to decode (1 = bundle accepted this cycle)
//   mem                  : data-memory read bus (master side)
//   output_valid, out_*,
//   left_value, right_value, destination_address : resolved operation toward execute
//
// state     | meaning
// PASS      | accepting decode bundles, one result per cycle
// MEM_WAIT  | read request outstanding, waiting for data_valid
// DATA_HELD | read data captured while execute was holding; emit when hold_n rises
module operand_read
  import operand_read_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                hold_n,
  input  logic                input_valid,
  input  regfile_t            registers,
  input  regval_t             in_pc,
  input  regval_t             in_adjustment,
  input  logic [OP_W-1:0]     in_operation,
  input  regidx_t             in_destination,
  input  regidx_t             in_left_register,
  input  regidx_t             in_right_register,
  input  logic                in_destination_is_memory,
  input  logic                in_right_is_memory,
  input  logic                in_adjustment_operation,
  input  logic                in_has_flushed,
  output logic                wait_n,
  operand_read_if.master      mem,
  output logic                output_valid,
  output regval_t             out_pc,
  output logic [OP_W-1:0]     out_operation,
  output regval_t             left_value,
  output regval_t             right_value,
  output regidx_t             out_destination,
  output regval_t             destination_address,
  output logic                out_destination_is_memory,
  output logic                out_has_flushed
);

  state_t          state, state_next;
  operand_bundle_t in_bundle, hold_q, out_q;
  regval_t         left_resolved, adjusted;
  logic            address_enable_q;
  regval_t         address_q;

  logic accept_reg, accept_mem, accept_flush, go_idle;
  logic emit_mem, emit_held, data_capture, addr_clear;

  operand_read_adjust u_adjust (
    .registers            (registers),
    .left_register        (in_left_register),
    .right_register       (in_right_register),
    .adjustment           (in_adjustment),
    .adjustment_operation (in_adjustment_operation),
    .left_value           (left_resolved),
    .adjusted_value       (adjusted)
  );

  always_comb begin
    in_bundle                       = '0;
    in_bundle.pc                    = in_pc;
    in_bundle.operation             = in_operation;
    in_bundle.left_value            = left_resolved;
    in_bundle.right_value           = adjusted;
    in_bundle.destination           = in_destination;
    in_bundle.destination_address   = in_destination_is_memory ? registers[in_destination] : '0;
    in_bundle.destination_is_memory = in_destination_is_memory;
    in_bundle.has_flushed           = in_has_flushed;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= PASS;
    else          state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept_reg   = 1'b0;
    accept_mem   = 1'b0;
    accept_flush = 1'b0;
    go_idle      = 1'b0;
    emit_mem     = 1'b0;
    emit_held    = 1'b0;
    data_capture = 1'b0;
    addr_clear   = 1'b0;
    case (state)
      PASS: begin
        if (hold_n) begin
          if (!input_valid)         go_idle = 1'b1;
          else if (in_has_flushed)  accept_flush = 1'b1;
          else if (!in_right_is_memory) accept_reg = 1'b1;
          else begin
            accept_mem = 1'b1;
            state_next = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (mem.data_valid) begin
          addr_clear = 1'b1;
          if (hold_n) begin
            emit_mem   = 1'b1;
            state_next = PASS;
          end else begin
            // execute is holding: park the data so memory is released
            data_capture = 1'b1;
            state_next   = DATA_HELD;
          end
        end
      end
      DATA_HELD: begin
        if (hold_n) begin
          emit_held  = 1'b1;
          state_next = PASS;
        end
      end
      default: state_next = PASS;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q            <= '0;
      hold_q           <= '0;
      output_valid     <= 1'b0;
      address_enable_q <= 1'b0;
      address_q        <= '0;
    end else begin
      if (accept_reg) begin
        out_q        <= in_bundle;
        output_valid <= 1'b1;
      end
      // flushed bundle: only the flush flag moves, the rest of the outputs keep their values
      if (accept_flush) begin
        out_q.has_flushed <= 1'b1;
        output_valid      <= 1'b0;
      end
      if (go_idle) begin
        out_q.has_flushed <= 1'b0;
        output_valid      <= 1'b0;
      end
      if (accept_mem) begin
        hold_q           <= in_bundle;
        address_enable_q <= 1'b1;
        address_q        <= adjusted;
        output_valid     <= 1'b0;
      end
      if (addr_clear)   address_enable_q   <= 1'b0;
      if (data_capture) hold_q.right_value <= mem.data;
      if (emit_mem) begin
        out_q             <= hold_q;
        out_q.right_value <= mem.data;
        output_valid      <= 1'b1;
      end
      if (emit_held) begin
        out_q        <= hold_q;
        output_valid <= 1'b1;
      end
    end
  end

  assign wait_n             = hold_n && (state == PASS);
  assign mem.address_enable = address_enable_q;
  assign mem.address        = address_q;

  assign out_pc                    = out_q.pc;
  assign out_operation             = out_q.operation;
  assign left_value                = out_q.left_value;
  assign right_value               = out_q.right_value;
  assign out_destination           = out_q.destination;
  assign destination_address       = out_q.destination_address;
  assign out_destination_is_memory = out_q.destination_is_memory;
  assign out_has_flushed           = out_q.has_flushed;

endmodule

// File: tb/tb_operand_read.sv
// Directed self-checking bench for operand_read.
module tb_operand_read;
  import operand_read_pkg::*;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            hold_n = 1'b1;
  logic            input_valid = 1'b0;
  regfile_t        registers = '0;
  regval_t         in_pc = '0;
  regval_t         in_adjustment = '0;
  logic [OP_W-1:0] in_operation = '0;
  regidx_t         in_destination = '0;
  regidx_t         in_left_register = '0;
  regidx_t         in_right_register = '0;
  logic            in_destination_is_memory = 1'b0;
  logic            in_right_is_memory = 1'b0;
  logic            in_adjustment_operation = 1'b0;
  logic            in_has_flushed = 1'b0;

  logic            wait_n;
  logic            output_valid;
  regval_t         out_pc;
  logic [OP_W-1:0] out_operation;
  regval_t         left_value, right_value;
  regidx_t         out_destination;
  regval_t         destination_address;
  logic            out_destination_is_memory, out_has_flushed;

  operand_read_if mem_bus ();

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  operand_read dut (
    .clock                     (clock),
    .reset_n                   (reset_n),
    .hold_n                    (hold_n),
    .input_valid               (input_valid),
    .registers                 (registers),
    .in_pc                     (in_pc),
    .in_adjustment             (in_adjustment),
    .in_operation              (in_operation),
    .in_destination            (in_destination),
    .in_left_register          (in_left_register),
    .in_right_register         (in_right_register),
    .in_destination_is_memory  (in_destination_is_memory),
    .in_right_is_memory        (in_right_is_memory),
    .in_adjustment_operation   (in_adjustment_operation),
    .in_has_flushed            (in_has_flushed),
    .wait_n                    (wait_n),
    .mem                       (mem_bus),
    .output_valid              (output_valid),
    .out_pc                    (out_pc),
    .out_operation             (out_operation),
    .left_value                (left_value),
    .right_value               (right_value),
    .out_destination           (out_destination),
    .destination_address       (destination_address),
    .out_destination_is_memory (out_destination_is_memory),
    .out_has_flushed           (out_has_flushed)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    checks++; if (output_valid !== 1'b0) begin failures++; $display("FAIL reset_output_valid got=%b exp=0", output_valid); end
    checks++; if (mem_bus.address_enable !== 1'b0) begin failures++; $display("FAIL reset_address_enable got=%b exp=0", mem_bus.address_enable); end
    checks++; if (mem_bus.address !== 32'h0) begin failures++; $display("FAIL reset_address got=%h exp=0", mem_bus.address); end
    checks++; if (out_pc !== 32'h0 || right_value !== 32'h0 || left_value !== 32'h0 || out_has_flushed !== 1'b0)
      begin failures++; $display("FAIL reset_outputs pc=%h right=%h left=%h fl=%b exp all 0", out_pc, right_value, left_value, out_has_flushed); end
    checks++; if (wait_n !== 1'b1) begin failures++; $display("FAIL reset_wait_n got=%b exp=1", wait_n); end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_register_op();
    registers[1] = 32'd5;
    registers[2] = 32'd7;
    in_pc = 32'h100; in_operation = 8'h21;
    in_left_register = 4'd1; in_right_register = 4'd2;
    in_adjustment = 32'd3; in_adjustment_operation = 1'b0;
    in_destination = 4'd4; in_destination_is_memory = 1'b0;
    in_right_is_memory = 1'b0; in_has_flushed = 1'b0;
    input_valid = 1'b1;
    #1;
    checks++; if (wait_n !== 1'b1) begin failures++; $display("FAIL regop_wait_n_before got=%b exp=1", wait_n); end
    tick();
    checks++; if (output_valid !== 1'b1) begin failures++; $display("FAIL regop_valid got=%b exp=1", output_valid); end
    checks++; if (left_value !== 32'd5) begin failures++; $display("FAIL regop_left got=%h exp=00000005", left_value); end
    checks++; if (right_value !== 32'h0000000A) begin failures++; $display("FAIL regop_right got=%h exp=0000000a", right_value); end
    checks++; if (out_pc !== 32'h100 || out_operation !== 8'h21 || out_destination !== 4'd4)
      begin failures++; $display("FAIL regop_fields pc=%h op=%h dst=%h exp 100/21/4", out_pc, out_operation, out_destination); end
    checks++; if (destination_address !== 32'h0) begin failures++; $display("FAIL regop_dest_addr got=%h exp=0", destination_address); end
    checks++; if (wait_n !== 1'b1) begin failures++; $display("FAIL regop_wait_n_after got=%b exp=1", wait_n); end
    input_valid = 1'b0;
    tick();
    checks++; if (output_valid !== 1'b0) begin failures++; $display("FAIL regop_idle_valid got=%b exp=0", output_valid); end
  endtask

  task automatic test_zero_sub();
    registers[0] = 32'h99;
    registers[3] = 32'h40;
    in_left_register = 4'd2; in_right_register = 4'd0;
    in_adjustment = 32'd1; in_adjustment_operation = 1'b1;
    in_destination = 4'd3; in_destination_is_memory = 1'b1;
    input_valid = 1'b1;
    tick();
    checks++; if (right_value !== 32'hFFFFFFFF) begin failures++; $display("FAIL zsub_right got=%h exp=ffffffff", right_value); end
    checks++; if (left_value !== 32'd7) begin failures++; $display("FAIL zsub_left got=%h exp=00000007", left_value); end
    checks++; if (destination_address !== 32'h40 || out_destination_is_memory !== 1'b1)
      begin failures++; $display("FAIL zsub_dest got=%h/%b exp=00000040/1", destination_address, out_destination_is_memory); end
    input_valid = 1'b0;
    in_destination_is_memory = 1'b0;
    in_adjustment_operation = 1'b0;
    tick();
  endtask

  task automatic test_memory_read();
    registers[2] = 32'h100;
    in_pc = 32'h200; in_operation = 8'h33;
    in_left_register = 4'd1; in_right_register = 4'd2;
    in_adjustment = 32'd4; in_adjustment_operation = 1'b0;
    in_destination = 4'd5; in_right_is_memory = 1'b1;
    input_valid = 1'b1;
    tick();
    checks++; if (mem_bus.address_enable !== 1'b1) begin failures++; $display("FAIL mem_addr_en got=%b exp=1", mem_bus.address_enable); end
    checks++; if (mem_bus.address !== 32'h104) begin failures++; $display("FAIL mem_address got=%h exp=00000104", mem_bus.address); end
    checks++; if (wait_n !== 1'b0) begin failures++; $display("FAIL mem_wait_n got=%b exp=0", wait_n); end
    checks++; if (output_valid !== 1'b0) begin failures++; $display("FAIL mem_valid_early got=%b exp=0", output_valid); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (mem_bus.address_enable !== 1'b1 || mem_bus.address !== 32'h104 || output_valid !== 1'b0)
        begin failures++; $display("FAIL mem_stall%0d en=%b addr=%h v=%b exp 1/00000104/0", i, mem_bus.address_enable, mem_bus.address, output_valid); end
    end
    mem_bus.data_valid = 1'b1;
    mem_bus.data = 32'hDEADBEEF;
    tick();
    checks++; if (output_valid !== 1'b1) begin failures++; $display("FAIL mem_valid got=%b exp=1", output_valid); end
    checks++; if (right_value !== 32'hDEADBEEF) begin failures++; $display("FAIL mem_right got=%h exp=deadbeef", right_value); end
    checks++; if (left_value !== 32'd5 || out_pc !== 32'h200 || out_operation !== 8'h33 || out_destination !== 4'd5)
      begin failures++; $display("FAIL mem_fields left=%h pc=%h op=%h dst=%h exp 5/200/33/5", left_value, out_pc, out_operation, out_destination); end
    checks++; if (wait_n !== 1'b1 || mem_bus.address_enable !== 1'b0)
      begin failures++; $display("FAIL mem_release wait_n=%b en=%b exp 1/0", wait_n, mem_bus.address_enable); end
    input_valid = 1'b0;
    in_right_is_memory = 1'b0;
    mem_bus.data_valid = 1'b0;
    tick();
    checks++; if (output_valid !== 1'b0) begin failures++; $display("FAIL mem_idle_valid got=%b exp=0", output_valid); end
  endtask

  task automatic test_flushed();
    in_pc = 32'h300; in_has_flushed = 1'b1; in_right_is_memory = 1'b1;
    input_valid = 1'b1;
    tick();
    checks++; if (mem_bus.address_enable !== 1'b0) begin failures++; $display("FAIL flush_addr_en got=%b exp=0", mem_bus.address_enable); end
    checks++; if (output_valid !== 1'b0 || out_has_flushed !== 1'b1)
      begin failures++; $display("FAIL flush_flags v=%b fl=%b exp 0/1", output_valid, out_has_flushed); end
    checks++; if (out_pc !== 32'h200 || right_value !== 32'hDEADBEEF)
      begin failures++; $display("FAIL flush_hold pc=%h right=%h exp 00000200/deadbeef", out_pc, right_value); end
    checks++; if (wait_n !== 1'b1) begin failures++; $display("FAIL flush_wait_n got=%b exp=1", wait_n); end
    input_valid = 1'b0; in_has_flushed = 1'b0; in_right_is_memory = 1'b0;
    tick();
    checks++; if (out_has_flushed !== 1'b0) begin failures++; $display("FAIL flush_clear got=%b exp=0", out_has_flushed); end
  endtask

  task automatic test_hold_freeze();
    in_pc = 32'h400; in_right_register = 4'd1; in_adjustment = 32'h10;
    input_valid = 1'b1;
    tick();
    checks++; if (output_valid !== 1'b1 || right_value !== 32'h15)
      begin failures++; $display("FAIL freeze_first v=%b right=%h exp 1/00000015", output_valid, right_value); end
    in_pc = 32'h500; in_adjustment = 32'h20;
    hold_n = 1'b0;
    #1;
    checks++; if (wait_n !== 1'b0) begin failures++; $display("FAIL freeze_wait_n got=%b exp=0", wait_n); end
    tick();
    tick();
    checks++; if (output_valid !== 1'b1 || right_value !== 32'h15 || out_pc !== 32'h400)
      begin failures++; $display("FAIL freeze_hold v=%b right=%h pc=%h exp 1/00000015/00000400", output_valid, right_value, out_pc); end
    hold_n = 1'b1;
    tick();
    checks++; if (out_pc !== 32'h500 || right_value !== 32'h25)
      begin failures++; $display("FAIL freeze_release pc=%h right=%h exp 00000500/00000025", out_pc, right_value); end
    input_valid = 1'b0;
    tick();
  endtask

  task automatic test_hold_data();
    in_pc = 32'h600; in_right_register = 4'd2;
    in_adjustment = 32'd8; in_adjustment_operation = 1'b1;
    in_right_is_memory = 1'b1;
    input_valid = 1'b1;
    tick();
    checks++; if (mem_bus.address_enable !== 1'b1 || mem_bus.address !== 32'hF8)
      begin failures++; $display("FAIL hdata_req en=%b addr=%h exp 1/000000f8", mem_bus.address_enable, mem_bus.address); end
    hold_n = 1'b0;
    mem_bus.data_valid = 1'b1;
    mem_bus.data = 32'h12345678;
    tick();
    mem_bus.data_valid = 1'b0;
    mem_bus.data = 32'h0BADBAD0;
    checks++; if (mem_bus.address_enable !== 1'b0 || wait_n !== 1'b0)
      begin failures++; $display("FAIL hdata_capture en=%b wait_n=%b exp 0/0", mem_bus.address_enable, wait_n); end
    checks++; if (output_valid !== 1'b0 || right_value !== 32'h25 || out_pc !== 32'h500)
      begin failures++; $display("FAIL hdata_frozen v=%b right=%h pc=%h exp 0/00000025/00000500", output_valid, right_value, out_pc); end
    tick();
    tick();
    checks++; if (output_valid !== 1'b0 || wait_n !== 1'b0)
      begin failures++; $display("FAIL hdata_held v=%b wait_n=%b exp 0/0", output_valid, wait_n); end
    hold_n = 1'b1;
    #1;
    checks++; if (wait_n !== 1'b0) begin failures++; $display("FAIL hdata_wait_before got=%b exp=0", wait_n); end
    tick();
    checks++; if (output_valid !== 1'b1 || right_value !== 32'h12345678 || out_pc !== 32'h600)
      begin failures++; $display("FAIL hdata_emit v=%b right=%h pc=%h exp 1/12345678/00000600", output_valid, right_value, out_pc); end
    checks++; if (wait_n !== 1'b1) begin failures++; $display("FAIL hdata_pass got=%b exp=1", wait_n); end
    input_valid = 1'b0;
    in_right_is_memory = 1'b0;
    in_adjustment_operation = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    in_right_register = 4'd2; in_adjustment = 32'd4;
    in_right_is_memory = 1'b1;
    input_valid = 1'b1;
    tick();
    checks++; if (mem_bus.address_enable !== 1'b1) begin failures++; $display("FAIL rstw_req got=%b exp=1", mem_bus.address_enable); end
    input_valid = 1'b0;
    in_right_is_memory = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (mem_bus.address_enable !== 1'b0 || output_valid !== 1'b0 || mem_bus.address !== 32'h0)
      begin failures++; $display("FAIL rstw_clear en=%b v=%b addr=%h exp 0/0/0", mem_bus.address_enable, output_valid, mem_bus.address); end
    checks++; if (wait_n !== 1'b1 || out_pc !== 32'h0)
      begin failures++; $display("FAIL rstw_state wait_n=%b pc=%h exp 1/0", wait_n, out_pc); end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    checks++; if (wait_n !== 1'b1 || mem_bus.address_enable !== 1'b0)
      begin failures++; $display("FAIL rstw_after wait_n=%b en=%b exp 1/0", wait_n, mem_bus.address_enable); end
  endtask

  initial begin
    mem_bus.data_valid = 1'b0;
    mem_bus.data = '0;
    test_reset();
    test_register_op();
    test_zero_sub();
    test_memory_read();
    test_flushed();
    test_hold_freeze();
    test_hold_data();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_read.md
Name: operand_read

Overview:
- Pipeline stage directly downstream of decode; consumes the decode-to-read bundle and produces resolved operands for the execute stage.
- Reads left/right source registers from the register file and applies the decode adjustment.
- When the right operand is a memory reference, issues a data read and stalls until the memory returns valid data.
- Registers one fully resolved operation per cycle toward execute, with hold/wait back-pressure toward decode.

Parameters:
- NR, 16, number of architectural registers; register 0 reads as zero; index width is $clog2(NR).
- OP_W, 8, width of the opaque operation field passed through to execute.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- hold_n  in  1  execute ready; 0 means freeze output registers.
- input_valid  in  1  decode output_valid.
- registers  in  NR*32  register file snapshot (regfile_t).
- in_pc  in  32  pc of the decoded instruction.
- in_adjustment  in  32  signed immediate/offset from decode.
- in_operation  in  OP_W  operation code.
- in_destination, in_left_register, in_right_register  in  $clog2(NR) each  register indices.
- in_destination_is_memory, in_right_is_memory, in_adjustment_operation, in_has_flushed  in  1 each.
- wait_n  out  1  to decode; 0 stalls decode.
- address_enable  out  1  data-memory read request.
- address  out  32  data-memory read address.
- data_valid  in  1  memory read data valid.
- data  in  32  memory read data.
- output_valid  out  1  outputs hold a real operation.
- out_pc  out  32.
- out_operation  out  OP_W.
- left_value, right_value  out  32 each.
- out_destination  out  $clog2(NR).
- destination_address  out  32  registers[destination] when destination_is_memory, else 0.
- out_destination_is_memory, out_has_flushed  out  1 each.

Behaviour:
- Reset (async, reset_n=0):
  - FSM to PASS.
  - output_valid=0, address_enable=0, address=0.
  - All out_* values 0.
  - wait_n=1.
- Operand arithmetic (32-bit, wrap-around, no overflow flag):
  - reg(i) = 0 if i==0 else registers[i].
  - left_value = reg(left).
  - Adjusted value A = reg(right) + adjustment when adjustment_operation=0; reg(right) - adjustment when 1.
- FSM PASS, accepting when hold_n=1 and input_valid=1:
  - If in_has_flushed=1: capture nothing. Next cycle output_valid=0, out_has_flushed=1, all other out_* hold previous values.
  - Else if right_is_memory=0: 1-cycle latency; next edge loads outputs with right_value=A and sets output_valid=1.
  - Else (memory read): on the same edge set address_enable=1 and address=A, latch all other fields into a holding register, and go to MEM_WAIT. output_valid=0 next cycle.
- FSM PASS, input_valid=0 with hold_n=1: next cycle output_valid=0 and out_has_flushed=0.
- FSM MEM_WAIT:
  - wait_n=0; address_enable stays 1 and address stable.
  - On data_valid=1 and hold_n=1: load outputs from the holding register with right_value=data, set output_valid=1, address_enable=0, and return to PASS.
  - On data_valid=1 while hold_n=0: capture data into the holding register and go to DATA_HELD with address_enable=0.
- FSM DATA_HELD:
  - wait_n=0.
  - When hold_n=1: emit as above and return to PASS.
- hold_n=0 in any state: output registers frozen; wait_n=0 combinationally; no new input accepted.
- wait_n combinational = hold_n && state==PASS.
- Decode must present the same bundle until the cycle it sees wait_n=1.
- Flush arriving while in MEM_WAIT: none is possible, since decode is stalled; the read completes normally.

Decomposition:
- Shared package (registers.sv): regval_t, regfile_t, NR, PC index.
- Shared package: state enum {PASS, MEM_WAIT, DATA_HELD} and an operand_bundle_t struct for the holding/output register.
- Natural sub-module: operand_adjust (combinational reg-zero mux plus add/subtract of the adjustment). The rest stays in one module.

Test Plan:
- Reset mid-MEM_WAIT (address_enable=1): drop reset_n asynchronously -> address_enable=0, output_valid=0, wait_n=1 immediately, FSM=PASS.
- Register op: registers r1=5, r2=7, left=1, right=2, adj=3, adj_op=0, valid=1, hold_n=1 -> next cycle output_valid=1, left_value=5, right_value=0000000A, wait_n stays 1.
- Zero register and subtract: right=0, adj=1, adj_op=1 -> right_value=FFFFFFFF.
- Memory read: right_is_memory=1, r2=00000100, adj=4 -> address_enable=1, address=00000104, wait_n=0. data_valid=1, data=DEADBEEF after 3 cycles -> next cycle output_valid=1, right_value=DEADBEEF, wait_n=1.
- Flushed input: in_has_flushed=1, right_is_memory=1 -> address_enable stays 0, output_valid=0, out_has_flushed=1.
- Hold during data return: hold_n=0 when data_valid=1 with data=12345678 -> outputs frozen, wait_n=0. hold_n=1 two cycles later -> right_value=12345678, output_valid=1, FSM=PASS.
